data_memory_ctrl: RTL and testbench
===================================

// Module: data_memory_ctrl
// PURPOSE
//  Multi-cycle data memory with request/acknowledge control. Produces the
//  word consumed by the accumulator-input mux on its data-memory leg
//  (sel_A = 2'b00). Accepts one read or write at a time from the control unit,
//  inserts READ_LATENCY wait cycles on reads, and holds the last read word stable.
// PARAMETERS
//  DATA_WIDTH    11   word width; matches the accumulator/mux datapath
//  ADDR_WIDTH    11   address width; DEPTH = 2**ADDR_WIDTH words
//  READ_LATENCY   1   wait cycles between read accept and data valid (1..7)
// PORTS
//  clk_in              in   1           system clock, rising edge
//  reset_in            in   1           asynchronous, active-high reset
//  addr_in             in   ADDR_WIDTH  word address, sampled on accept
//  data_in             in   DATA_WIDTH  write data (accumulator value), sampled on accept
//  rd_en_in            in   1           read request
//  wr_en_in            in   1           write request
//  data_memory_out     out  DATA_WIDTH  last completed read word -> mux data_memory_in
//  data_valid_out      out  1           1-cycle pulse: data_memory_out just updated
//  wr_done_out         out  1           1-cycle pulse: write committed
//  busy_out            out  1           controller not in IDLE; requests ignored
//  err_out             out  1           1-cycle pulse: rd_en_in and wr_en_in both high on accept
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, data_memory_out=0, data_valid_out=0,
//   wr_done_out=0, busy_out=0, err_out=0, wait counter=0. Array not reset.
//  FSM states: IDLE, READ_WAIT, READ_DONE, WRITE.
//  Accept: only in IDLE, on the rising edge where rd_en_in|wr_en_in=1;
//   addr_in/data_in latched on that edge. Requests while busy_out=1 are
//   dropped, not queued; the requester holds them until busy_out=0.
//  Read: IDLE -> READ_WAIT (counter loaded READ_LATENCY-1) -> decrement each
//   cycle -> at 0 go READ_DONE: data_memory_out <= mem[addr], data_valid_out=1
//   for that one cycle -> IDLE. Accept edge to data_valid_out high =
//   READ_LATENCY+1 cycles. data_memory_out holds until the next read completes.
//  Write: mem[addr] <= data written on the accept edge; state WRITE for one
//   cycle with wr_done_out=1, busy_out=1 -> IDLE.
//  Simultaneous rd_en_in & wr_en_in on accept: write performed, read
//   discarded, err_out=1 in the same cycle as wr_done_out.
//  Read-after-write, same address: the next accepted read returns new data
//   (write is committed before IDLE is re-entered).
//  busy_out = (state != IDLE); registered, high from the cycle after accept.
//  Reset mid-read: aborted, no data_valid_out. Reset mid-WRITE: array keeps
//   the already-committed word; wr_done_out is forced 0.
//  Address space fully decoded (DEPTH = 2**ADDR_WIDTH); no out-of-range case.
//  All outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  Shared package tcc_pkg: dmem_state_t enum {IDLE, READ_WAIT, READ_DONE,
//   WRITE}; sel_A codes (_DATA_MEMORY/_EXT/_ALU) so control unit and muxes agree.
//  One sub-module: sp_ram (single-port synchronous RAM, write-first,
//   DATA_WIDTH x 2**ADDR_WIDTH). FSM, wait counter and output registers
//   live in data_memory_ctrl.
// TESTING
//  1 Reset held 3 cycles mid-READ_WAIT -> all outputs 0, state IDLE,
//    no data_valid_out after release.
//  2 Write addr=0x005 data=0x3A5 then read 0x005 (READ_LATENCY=1) ->
//    wr_done_out pulse; data_valid_out 2 cycles after read accept; data_memory_out=0x3A5.
//  3 READ_LATENCY=3: read accept at cycle t -> data_valid_out only at t+4;
//    busy_out high t+1..t+4.
//  4 Request pulsed while busy_out=1 -> ignored: no extra pulse, memory
//    and data_memory_out unchanged.
//  5 rd_en_in=wr_en_in=1, addr=0x7FF, data=0x001 -> err_out and wr_done_out
//    same cycle; no data_valid_out; later read 0x7FF returns 0x001.
//  6 Back-to-back reads 0x000 then 0x7FF (wrap extremes) -> two valid pulses,
//    data_memory_out stable between them.

Source files
------------

// File: rtl/tcc_pkg.sv
// tcc_pkg: shared types and codes for the accumulator datapath and its data memory
package tcc_pkg;
  typedef enum logic [1:0] {IDLE, READ_WAIT, READ_DONE, WRITE} dmem_state_t;
  localparam logic [1:0] SEL_A_DATA_MEMORY = 2'b00;
  localparam logic [1:0] SEL_A_EXT         = 2'b01;
  localparam logic [1:0] SEL_A_ALU         = 2'b10;
  localparam int DMEM_DATA_WIDTH   = 11;
  localparam int DMEM_ADDR_WIDTH   = 11;
  localparam int DMEM_READ_LATENCY = 1;
  localparam int DMEM_CNT_WIDTH    = 3;
endpackage

// File: rtl/sp_ram.sv
// sp_ram: single-port synchronous RAM, write-first, one registered read port
module sp_ram #(
  parameter int DATA_WIDTH = 11,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
      rdata_o       <= wdata_i;
    end else begin
      rdata_o <= mem_q[addr_i];
    end
  end
endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: request/acknowledge data memory with programmable read wait cycles
module data_memory_ctrl
  import tcc_pkg::*;
#(
  parameter int DATA_WIDTH   = DMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DMEM_ADDR_WIDTH,
  parameter int READ_LATENCY = DMEM_READ_LATENCY
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en_in,
  input  logic                  wr_en_in,
  output logic [DATA_WIDTH-1:0] data_memory_out,
  output logic                  data_valid_out,
  output logic                  wr_done_out,
  output logic                  busy_out,
  output logic                  err_out
);
  dmem_state_t               state_q;
  logic [DMEM_CNT_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [ADDR_WIDTH-1:0]     ram_addr;
  logic [DATA_WIDTH-1:0]     ram_rdata;
  logic                      idle;
  logic                      ram_we;
  // In IDLE the RAM looks at the live address so a latency-1 read has data one edge after accept
  assign idle     = state_q == IDLE;
  assign ram_we   = idle & wr_en_in & ~reset_in;
  assign ram_addr = idle ? addr_in : addr_q;
  sp_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk_i   (clk_in),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (data_in),
    .rdata_o (ram_rdata)
  );
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      addr_q          <= '0;
      data_memory_out <= '0;
      data_valid_out  <= 1'b0;
      wr_done_out     <= 1'b0;
      busy_out        <= 1'b0;
      err_out         <= 1'b0;
    end else begin
      data_valid_out <= 1'b0;
      wr_done_out    <= 1'b0;
      err_out        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_en_in) begin
            state_q     <= WRITE;
            wr_done_out <= 1'b1;
            err_out     <= rd_en_in;
            busy_out    <= 1'b1;
          end else if (rd_en_in) begin
            state_q  <= READ_WAIT;
            cnt_q    <= DMEM_CNT_WIDTH'(READ_LATENCY - 1);
            addr_q   <= addr_in;
            busy_out <= 1'b1;
          end
        end
        READ_WAIT: begin
          if (cnt_q == '0) begin
            state_q         <= READ_DONE;
            data_memory_out <= ram_rdata;
            data_valid_out  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: randomized checks of two controllers (latency 1 and 3) against an array model
module tb_data_memory_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] addr [2];
  logic [10:0] din  [2];
  logic [10:0] dout [2];
  logic        rd [2], wr [2], valid [2], done [2], busy [2], err [2];
  logic [10:0] mem  [2][2048];
  bit          written [2][2048];
  logic [10:0] last [2];
  int          pass = 0;
  int          total = 0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DATA_WIDTH(11), .ADDR_WIDTH(11), .READ_LATENCY(1)) dut0 (
    .clk_in(clk), .reset_in(rst), .addr_in(addr[0]), .data_in(din[0]),
    .rd_en_in(rd[0]), .wr_en_in(wr[0]), .data_memory_out(dout[0]),
    .data_valid_out(valid[0]), .wr_done_out(done[0]), .busy_out(busy[0]), .err_out(err[0]));

  data_memory_ctrl #(.DATA_WIDTH(11), .ADDR_WIDTH(11), .READ_LATENCY(3)) dut1 (
    .clk_in(clk), .reset_in(rst), .addr_in(addr[1]), .data_in(din[1]),
    .rd_en_in(rd[1]), .wr_en_in(wr[1]), .data_memory_out(dout[1]),
    .data_valid_out(valid[1]), .wr_done_out(done[1]), .busy_out(busy[1]), .err_out(err[1]));

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic do_write(input int k, input logic [10:0] a, input logic [10:0] d, input bit both);
    @(negedge clk);
    addr[k] = a; din[k] = d; wr[k] = 1'b1; rd[k] = both;
    @(negedge clk);
    wr[k] = 1'b0; rd[k] = 1'b0;
    mem[k][a] = d; written[k][a] = 1'b1;
    total++; if (done[k] !== 1'b1) $display("FAIL wr_done k=%0d got=%b exp=1", k, done[k]); else pass++;
    total++; if (busy[k] !== 1'b1) $display("FAIL wr_busy k=%0d got=%b exp=1", k, busy[k]); else pass++;
    total++; if (err[k] !== both) $display("FAIL wr_err k=%0d got=%b exp=%b", k, err[k], both); else pass++;
    total++; if (valid[k] !== 1'b0) $display("FAIL wr_valid k=%0d got=%b exp=0", k, valid[k]); else pass++;
    @(negedge clk);
    total++; if (done[k] !== 1'b0) $display("FAIL wr_done_end k=%0d got=%b exp=0", k, done[k]); else pass++;
    total++; if (busy[k] !== 1'b0) $display("FAIL wr_busy_end k=%0d got=%b exp=0", k, busy[k]); else pass++;
    total++; if (err[k] !== 1'b0) $display("FAIL wr_err_end k=%0d got=%b exp=0", k, err[k]); else pass++;
    total++; if (valid[k] !== 1'b0) $display("FAIL wr_valid_end k=%0d got=%b exp=0", k, valid[k]); else pass++;
  endtask

  task automatic do_read(input int k, input logic [10:0] a);
    logic [10:0] exp_d;
    @(negedge clk);
    addr[k] = a; rd[k] = 1'b1; din[k] = 11'($urandom);
    for (int c = 1; c <= lat(k) + 1; c++) begin
      @(negedge clk);
      rd[k] = 1'b0;
      exp_d = (c == lat(k) + 1) ? mem[k][a] : last[k];
      total++; if (valid[k] !== (c == lat(k) + 1)) $display("FAIL rd_valid k=%0d c=%0d got=%b", k, c, valid[k]); else pass++;
      total++; if (busy[k] !== 1'b1) $display("FAIL rd_busy k=%0d c=%0d got=%b exp=1", k, c, busy[k]); else pass++;
      total++; if (dout[k] !== exp_d) $display("FAIL rd_data k=%0d c=%0d got=%h exp=%h", k, c, dout[k], exp_d); else pass++;
      total++; if (done[k] !== 1'b0) $display("FAIL rd_done k=%0d c=%0d got=%b exp=0", k, c, done[k]); else pass++;
    end
    last[k] = mem[k][a];
    @(negedge clk);
    total++; if (valid[k] !== 1'b0) $display("FAIL rd_valid_end k=%0d got=%b exp=0", k, valid[k]); else pass++;
    total++; if (busy[k] !== 1'b0) $display("FAIL rd_busy_end k=%0d got=%b exp=0", k, busy[k]); else pass++;
    total++; if (dout[k] !== last[k]) $display("FAIL rd_hold k=%0d got=%h exp=%h", k, dout[k], last[k]); else pass++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) last[k] = '0;
    do_write(1, 11'h010, 11'h2AA, 1'b0);
    @(negedge clk);
    addr[1] = 11'h010; rd[1] = 1'b1;
    @(negedge clk);
    rd[1] = 1'b0;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        total++; if ({dout[k], valid[k], done[k], busy[k], err[k]} !== '0)
          $display("FAIL reset_outs k=%0d got=%h exp=0", k, {dout[k], valid[k], done[k], busy[k], err[k]}); else pass++;
      end
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      total++; if ({valid[1], busy[1], dout[1]} !== '0)
        $display("FAIL reset_release got=%h exp=0", {valid[1], busy[1], dout[1]}); else pass++;
    end
  endtask

  task automatic test_write_read();
    do_write(0, 11'h005, 11'h3A5, 1'b0);
    do_read(0, 11'h005);
    total++; if (dout[0] !== 11'h3A5) $display("FAIL write_read got=%h exp=3a5", dout[0]); else pass++;
  endtask

  task automatic test_latency3();
    do_write(1, 11'h123, 11'h456, 1'b0);
    do_read(1, 11'h123);
  endtask

  task automatic test_busy_drop();
    do_write(1, 11'h020, 11'h111, 1'b0);
    do_write(1, 11'h030, 11'h222, 1'b0);
    @(negedge clk);
    addr[1] = 11'h020; rd[1] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      rd[1] = (c == 1); wr[1] = (c == 1); addr[1] = 11'h030; din[1] = 11'h555;
      total++; if (valid[1] !== (c == 4)) $display("FAIL busy_valid c=%0d got=%b", c, valid[1]); else pass++;
      total++; if ({done[1], err[1]} !== 2'b00) $display("FAIL busy_drop c=%0d got=%b exp=00", c, {done[1], err[1]}); else pass++;
      total++; if (busy[1] !== (c <= 4)) $display("FAIL busy_level c=%0d got=%b", c, busy[1]); else pass++;
    end
    total++; if (dout[1] !== 11'h111) $display("FAIL busy_data got=%h exp=111", dout[1]); else pass++;
    last[1] = 11'h111;
    do_read(1, 11'h030);
  endtask

  task automatic test_error();
    do_write(0, 11'h7FF, 11'h001, 1'b1);
    do_read(0, 11'h7FF);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin
      do_write(k, 11'h000, 11'($urandom), 1'b0);
      do_write(k, 11'h7FF, 11'($urandom), 1'b0);
      do_read(k, 11'h000);
      do_read(k, 11'h7FF);
    end
  endtask

  task automatic test_random();
    logic [10:0] pool [8];
    for (int i = 0; i < 8; i++) pool[i] = 11'($urandom);
    for (int n = 0; n < 60; n++) begin
      int k, i;
      k = int'($urandom_range(0, 1));
      i = int'($urandom_range(0, 7));
      if (!written[k][pool[i]] || $urandom_range(0, 2) == 0)
        do_write(k, pool[i], 11'($urandom), $urandom_range(0, 5) == 0);
      else
        do_read(k, pool[i]);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      addr[k] = '0; din[k] = '0; rd[k] = 1'b0; wr[k] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_latency3();
    test_busy_drop();
    test_error();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
